// File: rtl/game_ctrl.sv
// Game supervisor: collision detection, pipe scoring and the IDLE/PLAY/DYING/OVER state machine.
// Optional best-score tracking is enabled by defining GAME_CTRL_HISCORE_EN.
module game_ctrl #(
  parameter int BIRD_X    = 100,
  parameter int BIRD_HALF = 8,
  parameter int PIPE_W    = 40,
  parameter int GAP_H     = 120,
  parameter int Y_MIN     = 15,
  parameter int Y_MAX     = 465,
  parameter int DIE_TICKS = 20
) (
  input  logic       clk10,
  input  logic       clr,
  input  logic       start,
  input  logic [9:0] bird_y_pos,
  input  logic [9:0] pipe_x,
  input  logic [9:0] gap_y,
  output logic       game_end,
  output logic       playing,
  output logic       flash,
  output logic [7:0] score,
`ifdef GAME_CTRL_HISCORE_EN
  output logic [7:0] hi_score,
`endif
  output logic [1:0] dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DYING = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [10:0] BIRD_RIGHT = 11'(BIRD_X + BIRD_HALF);
  localparam logic [10:0] BIRD_LEFT  = 11'(BIRD_X - BIRD_HALF);
  localparam logic [10:0] PW         = 11'(PIPE_W);
  localparam logic [10:0] GH         = 11'(GAP_H);
  localparam logic [10:0] BH         = 11'(BIRD_HALF);
  localparam logic [10:0] YMN        = 11'(Y_MIN);
  localparam logic [10:0] YMX        = 11'(Y_MAX);
  localparam logic [4:0]  DIE_LAST   = 5'(DIE_TICKS - 1);

  logic [1:0]  state_q, state_d;
  logic        start_q;
  logic        armed_q, armed_d;
  logic        flash_q, flash_d;
  logic [7:0]  score_q, score_d;
  logic [4:0]  die_cnt_q, die_cnt_d;

  logic [10:0] by, px, gy, pipe_right;
  logic        h_ovl, v_miss, bound, hit, passed, start_edge;

  // 11-bit geometry so no sum can wrap; the top-of-bird compare is rearranged to avoid underflow
  assign by         = {1'b0, bird_y_pos};
  assign px         = {1'b0, pipe_x};
  assign gy         = {1'b0, gap_y};
  assign pipe_right = px + PW;
  assign h_ovl      = (px <= BIRD_RIGHT) && (pipe_right >= BIRD_LEFT);
  assign v_miss     = (by < gy + BH) || (by + BH > gy + GH);
  assign bound      = (by <= YMN) || (by >= YMX);
  assign hit        = (h_ovl && v_miss) || bound;
  assign passed     = pipe_right < BIRD_LEFT;
  assign start_edge = start & ~start_q;

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    flash_d   = 1'b0;
    score_d   = score_q;
    die_cnt_d = die_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_PLAY;
          score_d = 8'd0;
          armed_d = 1'b0;
        end
      end
      ST_PLAY: begin
        // a hit on the same tick as a pass takes priority and costs the point
        if (hit) begin
          state_d   = ST_DYING;
          die_cnt_d = 5'd0;
        end else if (armed_q && passed) begin
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          armed_d = 1'b0;
        end else if (!passed) begin
          armed_d = 1'b1;
        end
      end
      ST_DYING: begin
        die_cnt_d = die_cnt_q + 5'd1;
        flash_d   = ~flash_q;
        if (die_cnt_q == DIE_LAST) begin
          state_d = ST_OVER;
          flash_d = 1'b0;
        end
      end
      ST_OVER: begin
        if (start_edge) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk10 or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      armed_q   <= 1'b0;
      flash_q   <= 1'b0;
      score_q   <= 8'd0;
      die_cnt_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      armed_q   <= armed_d;
      flash_q   <= flash_d;
      score_q   <= score_d;
      die_cnt_q <= die_cnt_d;
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [7:0] hi_q;

  // best score survives start presses; only clr clears it
  always_ff @(posedge clk10 or negedge clr) begin
    if (!clr) begin
      hi_q <= 8'd0;
    end else if (state_q == ST_DYING && die_cnt_q == DIE_LAST && score_q > hi_q) begin
      hi_q <= score_q;
    end
  end

  assign hi_score = hi_q;
`endif

  assign game_end  = (state_q != ST_PLAY);
  assign playing   = (state_q == ST_PLAY);
  assign flash     = flash_q;
  assign score     = score_q;
  assign dbg_state = state_q;

endmodule
